// File: rtl/keyproc_rpt.sv
// keyproc_rpt: five-key synchroniser/debouncer, direction decoder with
// auto-repeat and a valid/ready command port. Option: KEYPROC_AUTO_REPEAT_EN.
module keyproc_rpt #(
   parameter int DEB_CYCLES    = 250000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int CMD_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       keys_raw,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_overrun,
   output logic             scramble,
   output logic             scramble_pulse
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

`ifdef KEYPROC_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW = $clog2(RMAX + 1);
   localparam logic [TW-1:0] T_DLY = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] T_PER = TW'(REPEAT_PERIOD - 1);
`else
   // Repeat timing has no effect when the timer is left out.
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_rpt_unused
   end
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_CHORD
`ifdef KEYPROC_AUTO_REPEAT_EN
      , S_REPEAT
`endif
   } state_t;

   logic [4:0]       r_s1;
   logic [4:0]       r_s2;
   logic [4:0]       r_stab;
   logic [4:0]       w_stab_nxt;
   logic [DW-1:0]    r_cnt [5];
   logic [DW-1:0]    w_cnt_nxt [5];
   logic [2:0]       w_code;
   state_t           r_st;
   state_t           w_st_nxt;
   logic [2:0]       r_last;
   logic [2:0]       w_last_nxt;
   logic             w_issue;
   logic             r_valid;
   logic [CMD_W-1:0] r_cmd;
   logic             r_ovr;
   logic             r_scr;
   logic             r_pulse;
`ifdef KEYPROC_AUTO_REPEAT_EN
   logic [TW-1:0]    r_tmr;
   logic [TW-1:0]    w_tmr_nxt;
`endif

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_stab_nxt[i] = r_stab[i];
         w_cnt_nxt[i]  = '0;
         if (r_s2[i] != r_stab[i]) begin
            if (r_cnt[i] == DEB_LAST)
               w_stab_nxt[i] = ~r_stab[i];
            else
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   // Decode the value the stable vector takes at this edge.
   always_comb begin
      w_code = 3'd0;
      priority case (1'b1)
         w_stab_nxt[4] & w_stab_nxt[3]: w_code = 3'd5;
         w_stab_nxt[4]:                 w_code = 3'd2;
         w_stab_nxt[3]:                 w_code = 3'd3;
         w_stab_nxt[2]:                 w_code = 3'd1;
         w_stab_nxt[1]:                 w_code = 3'd4;
         default:                       w_code = 3'd0;
      endcase
   end

   always_comb begin
      w_issue    = 1'b0;
      w_st_nxt   = r_st;
      w_last_nxt = r_last;
`ifdef KEYPROC_AUTO_REPEAT_EN
      w_tmr_nxt  = r_tmr;
`endif
      unique case (r_st)
         S_IDLE: begin
            if (w_code != 3'd0) begin
               w_issue    = 1'b1;
               w_last_nxt = w_code;
               w_st_nxt   = (w_code == 3'd5) ? S_CHORD : S_HOLD;
`ifdef KEYPROC_AUTO_REPEAT_EN
               w_tmr_nxt  = '0;
`endif
            end
         end
         S_CHORD: begin
            if (w_code == 3'd0)
               w_st_nxt = S_IDLE;
         end
         default: begin
            if (w_code == 3'd0) begin
               w_st_nxt = S_IDLE;
            end else if (w_code == 3'd5) begin
               w_issue    = 1'b1;
               w_last_nxt = w_code;
               w_st_nxt   = S_CHORD;
            end else if (w_code != r_last) begin
               // A new direction restarts the initial delay.
               w_issue    = 1'b1;
               w_last_nxt = w_code;
               w_st_nxt   = S_HOLD;
`ifdef KEYPROC_AUTO_REPEAT_EN
               w_tmr_nxt  = '0;
            end else if (r_st == S_HOLD && r_tmr == T_DLY) begin
               w_issue   = 1'b1;
               w_st_nxt  = S_REPEAT;
               w_tmr_nxt = '0;
            end else if (r_st == S_REPEAT && r_tmr == T_PER) begin
               w_issue   = 1'b1;
               w_tmr_nxt = '0;
            end else begin
               w_tmr_nxt = r_tmr + 1'b1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_stab  <= '0;
         for (int i = 0; i < 5; i++)
            r_cnt[i] <= '0;
         r_st    <= S_IDLE;
         r_last  <= '0;
         r_valid <= 1'b0;
         r_cmd   <= '0;
         r_ovr   <= 1'b0;
         r_scr   <= 1'b0;
         r_pulse <= 1'b0;
`ifdef KEYPROC_AUTO_REPEAT_EN
         r_tmr   <= '0;
`endif
      end else begin
         r_s1    <= keys_raw;
         r_s2    <= r_s1;
         r_stab  <= w_stab_nxt;
         for (int i = 0; i < 5; i++)
            r_cnt[i] <= w_cnt_nxt[i];
         r_st    <= w_st_nxt;
         r_last  <= w_last_nxt;
         r_scr   <= r_stab[0];
         r_pulse <= r_stab[0] & ~r_scr;
`ifdef KEYPROC_AUTO_REPEAT_EN
         r_tmr   <= w_tmr_nxt;
`endif
         if (w_issue) begin
            if (!r_valid || cmd_ready) begin
               r_cmd   <= CMD_W'(w_code);
               r_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && cmd_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign cmd_valid      = r_valid;
   assign cmd            = r_cmd;
   assign cmd_overrun    = r_ovr;
   assign scramble       = r_scr;
   assign scramble_pulse = r_pulse;

endmodule

// File: tb/tb_keyproc_rpt.sv
// tb_keyproc_rpt: directed plus random key stimulus against a behavioural
// model of the key processor, compared every cycle.
module tb_keyproc_rpt;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] keys_raw = '0;
   logic       cmd_ready = 1'b1;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic       cmd_overrun;
   logic       scramble;
   logic       scramble_pulse;

   always #5 clk = ~clk;

   keyproc_rpt #(
      .DEB_CYCLES   (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP),
      .CMD_W        (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .keys_raw      (keys_raw),
      .cmd_ready     (cmd_ready),
      .cmd_valid     (cmd_valid),
      .cmd           (cmd),
      .cmd_overrun   (cmd_overrun),
      .scramble      (scramble),
      .scramble_pulse(scramble_pulse)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int pulses = 0;
   int hs_cyc[$];
   int hs_cmd[$];

   // reference model state
   logic [4:0] m_d1, m_d2, m_stab;
   int         m_run[5];
   logic       m_scr, m_pulse, m_valid, m_ovr;
   logic [3:0] m_cmd;
   int         m_mode;   // 0 idle, 1 direction held, 3 chord
   int         m_last;
   int         m_since;

   function automatic int code_of(input logic [4:0] s);
      if (s[4] && s[3]) return 5;
      if (s[4]) return 2;
      if (s[3]) return 3;
      if (s[2]) return 1;
      if (s[1]) return 4;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [4:0] seen, old;
      int c;
      bit iss;
      if (!rst_n) begin
         m_d1 = '0; m_d2 = '0; m_stab = '0;
         for (int i = 0; i < 5; i++) m_run[i] = 0;
         m_scr = 0; m_pulse = 0; m_valid = 0; m_ovr = 0; m_cmd = '0;
         m_mode = 0; m_last = 0; m_since = 0;
         return;
      end
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = keys_raw;
      old  = m_stab;
      for (int i = 0; i < 5; i++) begin
         if (seen[i] != m_stab[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_stab[i] = ~m_stab[i];
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_pulse = old[0] & ~m_scr;
      m_scr   = old[0];
      c   = code_of(m_stab);
      iss = 0;
      case (m_mode)
         0: if (c != 0) begin
               iss = 1; m_last = c; m_since = cyc;
               m_mode = (c == 5) ? 3 : 1;
            end
         1: begin
            if (c == 0) m_mode = 0;
            else if (c == 5) begin iss = 1; m_last = 5; m_mode = 3; end
            else if (c != m_last) begin
               iss = 1; m_last = c; m_since = cyc;
            end
`ifdef KEYPROC_AUTO_REPEAT_EN
            else if ((cyc - m_since) >= RD &&
                     ((cyc - m_since - RD) % RP) == 0)
               iss = 1;
`endif
         end
         default: if (c == 0) m_mode = 0;
      endcase
      if (iss) begin
         if (!m_valid || cmd_ready) begin
            m_cmd = c[3:0];
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && cmd_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      chk("cmd_valid", cmd_valid, m_valid);
      chk("cmd", cmd, m_cmd);
      chk("cmd_overrun", cmd_overrun, m_ovr);
      chk("scramble", scramble, m_scr);
      chk("scramble_pulse", scramble_pulse, m_pulse);
      if (cmd_valid && cmd_ready) begin
         hs_cyc.push_back(cyc);
         hs_cmd.push_back(int'(cmd));
      end
      if (scramble_pulse) pulses++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_log();
      hs_cyc.delete();
      hs_cmd.delete();
   endtask

   function automatic int first_cmd();
      return (hs_cmd.size() > 0) ? hs_cmd[0] : -1;
   endfunction

   // Bounces shorter than DEB cycles, then settles at v.
   task automatic bounce(input int k, input bit v);
      for (int j = 0; j < 3; j++) begin
         keys_raw[k] = v;
         ticks($urandom_range(1, DEB - 1));
         keys_raw[k] = ~v;
         ticks($urandom_range(1, DEB - 1));
      end
      keys_raw[k] = v;
   endtask

   initial begin
      int p;
      int n_exp;
      int off[6];
      off = '{6, 26, 34, 42, 50, 58};

      // reset
      ticks(3);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_overrun", cmd_overrun, 0);
      chk("rst_scramble", scramble, 0);
      rst_n = 1'b1;
      ticks(4);

      // clean North press and release
      clear_log();
      p = cyc;
      keys_raw[2] = 1'b1;
      ticks(10);
      chk("north_count", hs_cyc.size(), 1);
      chk("north_code", first_cmd(), 1);
      chk("north_lat", (hs_cyc.size() > 0) ? hs_cyc[0] - p : -1, 6);
      clear_log();
      keys_raw[2] = 1'b0;
      ticks(12);
      chk("north_release", hs_cyc.size(), 0);

      // bouncy North press and release
      clear_log();
      bounce(2, 1'b1);
      p = cyc;
      ticks(10);
      chk("bounce_count", hs_cyc.size(), 1);
      chk("bounce_code", first_cmd(), 1);
      chk("bounce_lat", (hs_cyc.size() > 0) ? hs_cyc[0] - p : -1, 6);
      clear_log();
      bounce(2, 1'b0);
      ticks(10);
      chk("bounce_release", hs_cyc.size(), 0);

      // East held: initial command plus repeats
      clear_log();
      p = cyc;
      keys_raw[4] = 1'b1;
      ticks(56);
      keys_raw[4] = 1'b0;
      ticks(10);
`ifdef KEYPROC_AUTO_REPEAT_EN
      n_exp = 6;
`else
      n_exp = 1;
`endif
      chk("east_count", hs_cyc.size(), n_exp);
      for (int i = 0; i < n_exp && i < hs_cyc.size(); i++) begin
         chk("east_time", hs_cyc[i] - p, off[i]);
         chk("east_code", hs_cmd[i], 2);
      end

      // East then West chord, West released first
      clear_log();
      keys_raw[4] = 1'b1;
      ticks(10);
      keys_raw[3] = 1'b1;
      ticks(100);
      keys_raw[3] = 1'b0;
      ticks(20);
      keys_raw[4] = 1'b0;
      ticks(20);
      chk("chord_count", hs_cyc.size(), 2);
      chk("chord_first", first_cmd(), 2);
      chk("chord_second", (hs_cmd.size() > 1) ? hs_cmd[1] : -1, 5);

      // consumer stalled: second command dropped
      cmd_ready = 1'b0;
      keys_raw[2] = 1'b1;
      ticks(10);
      keys_raw[2] = 1'b0;
      ticks(10);
      keys_raw[1] = 1'b1;
      ticks(10);
      keys_raw[1] = 1'b0;
      ticks(10);
      chk("stall_valid", cmd_valid, 1);
      chk("stall_cmd", cmd, 1);
      chk("stall_overrun", cmd_overrun, 1);
      cmd_ready = 1'b1;
      ticks(1);
      chk("drain_valid", cmd_valid, 0);
      chk("drain_overrun", cmd_overrun, 1);

      // Scramble while West repeats, then reset mid-repeat
      clear_log();
      pulses = 0;
      keys_raw[3] = 1'b1;
      ticks(8);
      keys_raw[0] = 1'b1;
      ticks(40);
`ifdef KEYPROC_AUTO_REPEAT_EN
      n_exp = 4;
`else
      n_exp = 1;
`endif
      chk("scr_level", scramble, 1);
      chk("scr_pulses", pulses, 1);
      chk("west_count", hs_cyc.size(), n_exp);
      chk("west_code", first_cmd(), 3);
      rst_n = 1'b0;
      ticks(1);
      chk("mid_rst_valid", cmd_valid, 0);
      chk("mid_rst_cmd", cmd, 0);
      chk("mid_rst_overrun", cmd_overrun, 0);
      chk("mid_rst_scramble", scramble, 0);
      chk("mid_rst_pulse", scramble_pulse, 0);
      ticks(2);
      rst_n = 1'b1;
      ticks(30);
      keys_raw = '0;
      ticks(20);

      // random keys and ready, model-checked every cycle
      for (int s = 0; s < 40; s++) begin
         keys_raw  = 5'($urandom_range(0, 31));
         cmd_ready = 1'($urandom_range(0, 3) != 0);
         ticks($urandom_range(1, 40));
      end
      keys_raw  = '0;
      cmd_ready = 1'b1;
      ticks(20);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
